lab2_proc_imm_gen_pipe: RTL and testbench

LAB2_PROC_IMM_GEN_PIPE -- requirements
Module: lab2_proc_imm_gen_pipe

---
 rtl/lab2_proc_imm_gen_pipe.sv | 93 +++++++++
 tb/tb_lab2_proc_imm_gen_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_imm_gen_pipe.sv
// RISC-V immediate generator with a small output FIFO: decodes at enqueue, one-cycle minimum latency.
// in_rdy depends only on occupancy (never on out_rdy); squash and reset drop every buffered entry.
module lab2_proc_imm_gen_pipe #(
  parameter int p_xlen        = 32,
  parameter int p_num_entries = 2,
  parameter int p_tag_nbits   = 4
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [31:0]            in_inst,
  input  logic [2:0]             in_imm_type,
  input  logic [p_tag_nbits-1:0] in_tag,
  input  logic                   squash,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_xlen-1:0]      out_imm,
  output logic [p_tag_nbits-1:0] out_tag,
  output logic                   out_err
);

  localparam int c_ptr_nbits = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int c_cnt_nbits = $clog2(p_num_entries + 1);
  localparam logic [c_ptr_nbits-1:0] c_last = c_ptr_nbits'(p_num_entries - 1);
  localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_entries);

  typedef struct packed {
    logic [p_xlen-1:0]      imm;
    logic [p_tag_nbits-1:0] tag;
    logic                   err;
  } entry_t;

  entry_t                 mem [p_num_entries];
  entry_t                 new_entry;
  logic [c_ptr_nbits-1:0] head;
  logic [c_ptr_nbits-1:0] tail;
  logic [c_cnt_nbits-1:0] count;
  logic                   enq;
  logic                   deq;

  // Opcode bits never contribute to any immediate format.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, in_inst[6:0]};

  always_comb begin
    new_entry     = '0;
    new_entry.tag = in_tag;
    case (in_imm_type)
      3'd0: new_entry.imm = p_xlen'($signed(in_inst[31:20]));
      3'd1: new_entry.imm = p_xlen'($signed({in_inst[31:25], in_inst[11:7]}));
      3'd2: new_entry.imm = p_xlen'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                              in_inst[11:8], 1'b0}));
      3'd3: new_entry.imm = p_xlen'($signed({in_inst[31:12], 12'b0}));
      3'd4: new_entry.imm = p_xlen'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                              in_inst[30:21], 1'b0}));
      3'd5: begin
        if (p_xlen == 64) new_entry.imm = p_xlen'(in_inst[25:20]);
        else              new_entry.imm = p_xlen'(in_inst[24:20]);
      end
      3'd6: new_entry.imm = p_xlen'(in_inst[19:15]);
      default: new_entry.err = 1'b1;
    endcase
  end

  assign in_rdy  = (count < c_full) && reset;
  assign out_val = (count != '0);
  assign enq     = in_val && in_rdy && !squash;
  assign deq     = out_val && out_rdy && !squash;

  // Gate the head so stale storage never leaks onto the outputs while empty.
  assign out_imm = out_val ? mem[head].imm : '0;
  assign out_tag = out_val ? mem[head].tag : '0;
  assign out_err = out_val ? mem[head].err : 1'b0;

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= (tail == c_last) ? '0 : tail + 1'b1;
      if (deq) head <= (head == c_last) ? '0 : head + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_lab2_proc_imm_gen_pipe.sv
// Directed bench: decode table on 32- and 64-bit instances, plus full, squash and reset scenarios.
module tb_lab2_proc_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_type;
  logic [3:0]  in_tag;
  logic        squash;
  logic        out_rdy;

  logic        in_rdy, out_val, out_err;
  logic [31:0] out_imm;
  logic [3:0]  out_tag;

  logic        in_rdy64, out_val64, out_err64;
  logic [63:0] out_imm64;
  logic [3:0]  out_tag64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lab2_proc_imm_gen_pipe dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst),
    .in_imm_type(in_imm_type), .in_tag(in_tag), .squash(squash), .out_val(out_val),
    .out_rdy(out_rdy), .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
  );

  lab2_proc_imm_gen_pipe #(.p_xlen(64)) dut64 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy64), .in_inst(in_inst),
    .in_imm_type(in_imm_type), .in_tag(in_tag), .squash(squash), .out_val(out_val64),
    .out_rdy(out_rdy), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [2:0] ty, input logic [3:0] tag);
    in_val      = 1'b1;
    in_inst     = inst;
    in_imm_type = ty;
    in_tag      = tag;
  endtask

  // Decode vectors: instruction, type, expected 32-bit and 64-bit immediates.
  logic [31:0] v_inst  [9] = '{32'hFFF00093, 32'h7FF00093, 32'hFE112C23, 32'hFE000EE3,
                               32'h80000037, 32'h12345037, 32'hFFDFF06F, 32'h03F01013,
                               32'h800F8073};
  logic [2:0]  v_type  [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] v_exp32 [9] = '{32'hFFFFFFFF, 32'h000007FF, 32'hFFFFFFF8, 32'hFFFFFFFC,
                               32'h80000000, 32'h12345000, 32'hFFFFFFFC, 32'h0000001F,
                               32'h0000001F};
  logic [63:0] v_exp64 [9] = '{64'hFFFFFFFFFFFFFFFF, 64'h7FF, 64'hFFFFFFFFFFFFFFF8,
                               64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'h12345000,
                               64'hFFFFFFFFFFFFFFFC, 64'h3F, 64'h1F};

  initial begin
    reset = 1'b0; in_val = 1'b0; in_inst = '0; in_imm_type = '0; in_tag = '0;
    squash = 1'b0; out_rdy = 1'b0;
    tick(); tick();
    check("rst_out_val", out_val, 0);
    check("rst_in_rdy",  in_rdy,  0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_err", out_err, 0);

    reset = 1'b1;
    #1;
    check("post_rst_in_rdy", in_rdy, 1);

    // I-type with tag
    out_rdy = 1'b1;
    drive(32'hFFF00093, 3'd0, 4'd3);
    tick();
    in_val = 1'b0;
    check("i_out_val", out_val, 1);
    check("i_out_imm", out_imm, 32'hFFFFFFFF);
    check("i_out_tag", out_tag, 3);
    check("i_out_err", out_err, 0);
    tick();
    check("i_drained", out_val, 0);

    for (int i = 0; i < 9; i++) begin
      drive(v_inst[i], v_type[i], 4'(i));
      tick();
      in_val = 1'b0;
      check($sformatf("dec%0d_imm32", i), out_imm, v_exp32[i]);
      check($sformatf("dec%0d_imm64", i), out_imm64, v_exp64[i]);
      check($sformatf("dec%0d_err", i), out_err, 0);
      tick();
    end

    // Full buffer and FIFO order
    out_rdy = 1'b0;
    drive(32'h00100093, 3'd0, 4'd1);
    tick();
    drive(32'h00200093, 3'd0, 4'd2);
    tick();
    check("full_in_rdy", in_rdy, 0);
    check("full_head_tag", out_tag, 1);
    drive(32'h00300093, 3'd0, 4'd3);
    tick();
    check("full_hold_in_rdy", in_rdy, 0);
    check("full_hold_tag", out_tag, 1);
    out_rdy = 1'b1;
    #1;
    check("full_no_comb_rdy", in_rdy, 0);
    tick();
    check("order_tag2", out_tag, 2);
    check("order_rdy", in_rdy, 1);
    tick();
    in_val = 1'b0;
    check("order_tag3", out_tag, 3);
    check("order_imm3", out_imm, 3);
    check("order_val3", out_val, 1);
    tick();
    check("order_drained", out_val, 0);

    // Illegal type followed by shamt
    out_rdy = 1'b0;
    drive(32'hFFFFFFFF, 3'd7, 4'd6);
    tick();
    drive(32'h01F00013, 3'd5, 4'd7);
    check("ill_err", out_err, 1);
    check("ill_imm", out_imm, 0);
    check("ill_tag", out_tag, 6);
    out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    check("shamt_imm", out_imm, 31);
    check("shamt_err", out_err, 0);
    check("shamt_tag", out_tag, 7);
    tick();

    // Squash with two buffered entries and a concurrent request
    out_rdy = 1'b0;
    drive(32'h00100093, 3'd0, 4'd1);
    tick();
    drive(32'h00200093, 3'd0, 4'd2);
    tick();
    drive(32'h00900093, 3'd0, 4'd9);
    squash  = 1'b1;
    out_rdy = 1'b1;
    tick();
    squash = 1'b0;
    in_val = 1'b0;
    check("sq_out_val", out_val, 0);
    check("sq_out_tag", out_tag, 0);
    check("sq_out_imm", out_imm, 0);
    check("sq_in_rdy", in_rdy, 1);
    tick();
    check("sq_not_emitted", out_val, 0);
    drive(32'h00400093, 3'd0, 4'd4);
    tick();
    in_val = 1'b0;
    check("sq_after_tag", out_tag, 4);
    check("sq_after_imm", out_imm, 4);
    tick();

    // Reset mid-stream
    out_rdy = 1'b0;
    drive(32'h00500093, 3'd0, 4'd5);
    tick();
    in_val = 1'b0;
    check("mid_buffered", out_val, 1);
    reset = 1'b0;
    tick();
    check("mid_rst_out_val", out_val, 0);
    check("mid_rst_in_rdy", in_rdy, 0);
    reset = 1'b1;
    #1;
    check("mid_rel_in_rdy", in_rdy, 1);
    check("mid_rel_out_val", out_val, 0);
    tick();
    check("mid_not_emitted", out_val, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
